// File: rtl/prga_fifo_rr_arbiter_pkg.sv
// Shared types and elaboration helpers for the prga FIFO round-robin arbiter family.
package prga_fifo_rr_arbiter_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/prga_fifo_rr_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after base, modulo N.
module prga_rr_pick
  import prga_fifo_rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Doubled request vector so a scan from base never has to wrap explicitly.
  logic [2*N-2:0] dbl;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  always_comb begin
    dbl     = {req_i[N-2:0], req_i};
    off     = '0;
    sum     = '0;
    valid_o = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[int'(base_i) + k]) off = (IW + 1)'(k);
    end
    sum = {1'b0, base_i} + off;
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx_o = sum[IW-1:0];
  end

endmodule

// File: rtl/prga_fifo_rr_arbiter.sv
// Merges NUM_SRC lookahead FIFO read ports into one FIFO write port, round-robin with bounded bursts.
module prga_fifo_rr_arbiter
  import prga_fifo_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW = idx_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_SRC-1:0]            src_empty,
  output logic [NUM_SRC-1:0]            src_rd,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
  input  logic                          full,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         din,
  output logic [IW-1:0]                 grant_id
);

  localparam int CW = idx_w(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NUM_SRC-1:0]    eligible;
  logic                  lock_hit;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic                  sel_valid;
  logic [IW-1:0]         sel;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         cnt_inc;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_SRC - 1)) ? '0 : v + 1'b1;
  endfunction

  assign eligible = src_en & ~src_empty;
  assign lock_hit = (state_q == ST_LOCKED) && eligible[grant_q];

  prga_rr_pick #(
    .N (NUM_SRC)
  ) u_pick (
    .req_i   (eligible),
    .base_i  (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign sel       = lock_hit ? grant_q : pick_idx;
  assign sel_valid = lock_hit | pick_valid;

  // Handshake: a word moves exactly when a source is selected (valid) and the
  // downstream FIFO is not full (ready); the pop and the push share that cycle.
  assign xfer    = sel_valid && !full && !rst;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    head   = '0;
    src_rd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == IW'(i)) begin
        head      = src_dout[i*DATA_WIDTH +: DATA_WIDTH];
        src_rd[i] = xfer;
      end
    end
  end

  assign wr       = xfer;
  assign din      = xfer ? head : '0;
  assign grant_id = rst ? '0 : (xfer ? sel : grant_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    // A held lock is released as soon as its source stops being eligible, even when stalled.
    if (state_q == ST_LOCKED && !lock_hit) begin
      state_d = ST_UNLOCKED;
      ptr_d   = wrap_inc(grant_q);
      cnt_d   = '0;
    end
    if (xfer) begin
      if (lock_hit) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(MAX_BURST)) begin
          state_d = ST_UNLOCKED;
          ptr_d   = wrap_inc(grant_q);
          cnt_d   = '0;
        end
      end else begin
        grant_d = sel;
        cnt_d   = CW'(1);
        if (MAX_BURST == 1) begin
          state_d = ST_UNLOCKED;
          ptr_d   = wrap_inc(sel);
        end else begin
          state_d = ST_LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prga_fifo_rr_arbiter.sv
// Directed bench: 4-source/burst-4 instance for ordering, stall, mask and reset; 3-source/burst-1 for alternation.
module tb_prga_fifo_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  src_en_a, src_empty_a, src_rd_a;
  logic [31:0] src_dout_a;
  logic        full_a, wr_a;
  logic [7:0]  din_a;
  logic [1:0]  grant_id_a;

  logic [2:0]  src_en_b, src_empty_b, src_rd_b;
  logic [23:0] src_dout_b;
  logic        full_b, wr_b;
  logic [7:0]  din_b;
  logic [1:0]  grant_id_b;

  prga_fifo_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst(rst), .src_en(src_en_a), .src_empty(src_empty_a), .src_rd(src_rd_a),
    .src_dout(src_dout_a), .full(full_a), .wr(wr_a), .din(din_a), .grant_id(grant_id_a)
  );

  prga_fifo_rr_arbiter #(.NUM_SRC(3), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst(rst), .src_en(src_en_b), .src_empty(src_empty_b), .src_rd(src_rd_b),
    .src_dout(src_dout_b), .full(full_b), .wr(wr_b), .din(din_b), .grant_id(grant_id_b)
  );

  int tests = 0;
  int fails = 0;
  int cnt_a[4];
  int cnt_b[3];
  logic [7:0] head_a[4];
  logic [7:0] head_b[3];
  logic [7:0] exp_q[$];
  int gid_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      src_empty_a[i]        = (cnt_a[i] <= 0);
      src_dout_a[i*8 +: 8]  = head_a[i];
    end
    for (int i = 0; i < 3; i++) begin
      src_empty_b[i]        = (cnt_b[i] <= 0);
      src_dout_b[i*8 +: 8]  = head_b[i];
    end
  endtask

  // Source FIFO models pop on the edge where the DUT strobed src_rd.
  task automatic tick();
    logic [3:0] ra;
    logic [2:0] rb;
    ra = src_rd_a;
    rb = src_rd_b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ra[i]) begin
        head_a[i] = head_a[i] + 8'd1;
        cnt_a[i]--;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (rb[i]) begin
        head_b[i] = head_b[i] + 8'd1;
        cnt_b[i]--;
      end
    end
    drive();
  endtask

  task automatic xfer_a(input string tag, input logic [7:0] d, input int g);
    @(negedge clk);
    chk({tag, "_wr"}, wr_a, 1);
    chk({tag, "_din"}, din_a, d);
    chk({tag, "_gid"}, grant_id_a, g);
    chk({tag, "_rd"}, src_rd_a, 32'(1) << g);
    tick();
  endtask

  task automatic idle_a(input string tag, input int g);
    @(negedge clk);
    chk({tag, "_wr"}, wr_a, 0);
    chk({tag, "_rd"}, src_rd_a, 0);
    chk({tag, "_din"}, din_a, 0);
    chk({tag, "_gid"}, grant_id_a, g);
    tick();
  endtask

  task automatic xfer_b(input string tag, input logic [7:0] d, input int g);
    @(negedge clk);
    chk({tag, "_wr"}, wr_b, 1);
    chk({tag, "_din"}, din_b, d);
    chk({tag, "_gid"}, grant_id_b, g);
    chk({tag, "_rd"}, src_rd_b, 32'(1) << g);
    tick();
  endtask

  task automatic drain_a(input string tag);
    while (exp_q.size() > 0) xfer_a(tag, exp_q.pop_front(), gid_q.pop_front());
  endtask

  task automatic push_burst(input logic [7:0] first, input int n, input int g);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(first + 8'(k));
      gid_q.push_back(g);
    end
  endtask

  initial begin
    logic [7:0] base1[4];
    base1 = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    rst = 1'b1;
    full_a = 1'b0;
    full_b = 1'b0;
    src_en_a = 4'hF;
    src_en_b = 3'h7;
    for (int i = 0; i < 4; i++) begin
      head_a[i] = base1[i];
      cnt_a[i]  = 8;
    end
    for (int i = 0; i < 3; i++) begin
      head_b[i] = 8'h00;
      cnt_b[i]  = 0;
    end
    drive();

    // Reset: outputs gated while sources already hold data.
    idle_a("rst", 0);
    tick();
    rst = 1'b0;

    // Full-rate round robin, bursts of four.
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++) push_burst(base1[s] + 8'(r * 4), 4, s);
    drain_a("rr");
    idle_a("rr_done", 3);

    // Lone source runs dry before its burst limit, then source 0 is taken at once.
    head_a[2] = 8'h20; cnt_a[2] = 3; drive();
    push_burst(8'h20, 3, 2);
    drain_a("short");
    idle_a("short_rel", 2);
    head_a[0] = 8'h05; cnt_a[0] = 1; drive();
    xfer_a("s0_next", 8'h05, 0);
    idle_a("s0_rel", 0);

    // Downstream stall mid-burst on source 1.
    head_a[1] = 8'h10; cnt_a[1] = 4;
    head_a[2] = 8'h20; cnt_a[2] = 2; drive();
    push_burst(8'h10, 2, 1);
    drain_a("pre_stall");
    full_a = 1'b1;
    for (int c = 0; c < 5; c++) idle_a("stall", 1);
    full_a = 1'b0;
    push_burst(8'h12, 2, 1);
    push_burst(8'h20, 2, 2);
    drain_a("resume");
    idle_a("resume_rel", 2);

    // Source 2 masked off; pointer starts at 3 after the last release.
    src_en_a = 4'b1011;
    head_a[0] = 8'h40; head_a[1] = 8'h50; head_a[2] = 8'h60; head_a[3] = 8'h70;
    for (int i = 0; i < 4; i++) cnt_a[i] = 16;
    drive();
    push_burst(8'h70, 4, 3);
    push_burst(8'h40, 4, 0);
    push_burst(8'h50, 4, 1);
    push_burst(8'h74, 2, 3);
    drain_a("mask");

    // Reset mid-burst on source 3; scan restarts at 0 without losing or repeating words.
    rst = 1'b1;
    idle_a("mid_rst", 0);
    rst = 1'b0;
    push_burst(8'h44, 4, 0);
    push_burst(8'h54, 4, 1);
    push_burst(8'h76, 4, 3);
    drain_a("post_rst");
    chk("src2_untouched", 32'(cnt_a[2]), 16);
    chk("src3_head", head_a[3], 8'h7A);

    // Single-word bursts over three sources.
    head_b[0] = 8'h80; head_b[1] = 8'h90; head_b[2] = 8'hA0;
    for (int i = 0; i < 3; i++) cnt_b[i] = 4;
    drive();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++) xfer_b("alt", head_b[s], s);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
